uart_number_reporter: RTL and testbench

//   Transmit-side counterpart to the 4-digit display path. On request, sends the counter

---
 rtl/uart_number_reporter.sv | 185 ++++++++++++++++++
 tb/tb_uart_number_reporter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_number_reporter.sv
// Sends a snapshot of a packed multi-digit number as ASCII hex digits followed by CR LF
// over an 8N1 serial line. All outputs are registered and follow the FSM state by one cycle.
module uart_number_reporter #(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int BAUD_RATE                   = 115_200,
  parameter int NUMBER_OF_DIGITS            = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT    = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  send,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0]  number,
  output logic                                                  busy,
  output logic                                                  done,
  output logic                                                  tx
);

  localparam int D            = NUMBER_OF_DIGITS;
  localparam int B            = NUMBER_OF_BITS_PER_DIGIT;
  localparam int NUM_W        = D * B;
  localparam int CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NCHARS       = D + 2;
  localparam int CIDX_W       = $clog2(NCHARS);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(NCHARS - 1);
  localparam logic [3:0]        NIB_MASK  = (B >= 4) ? 4'hF : 4'((1 << B) - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  // Character idx of the report: digits MSD first (low 4 bits of each field), then CR, LF.
  function automatic logic [7:0] char_at(input logic [CIDX_W-1:0] idx,
                                         input logic [NUM_W-1:0]  snap);
    logic [3:0] nib;
    int         sh;
    nib = 4'h0;
    sh  = 0;
    if (int'(idx) < D) begin
      sh  = (D - 1 - int'(idx)) * B;
      nib = 4'(snap >> sh) & NIB_MASK;
      if (nib < 4'd10) begin
        char_at = 8'h30 + {4'h0, nib};
      end else begin
        char_at = 8'h41 + ({4'h0, nib} - 8'h0A);
      end
    end else if (int'(idx) == D) begin
      char_at = 8'h0D;
    end else begin
      char_at = 8'h0A;
    end
  endfunction

  state_t              state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [2:0]          bit_idx_q,  bit_idx_d;
  logic [CIDX_W-1:0]   char_idx_q, char_idx_d;
  logic [7:0]          shift_q,    shift_d;
  logic [NUM_W-1:0]    snap_q,     snap_d;
  logic                tx_q,       tx_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;

  // State register and registered outputs; async reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      char_idx_q <= '0;
      shift_q    <= 8'h00;
      snap_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      shift_q    <= shift_d;
      snap_q     <= snap_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; the line level is derived from the current state, so tx lags state by one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    shift_d    = shift_q;
    snap_d     = snap_q;
    tx_d       = 1'b1;
    busy_d     = 1'b1;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = send;
        if (send) begin
          snap_d     = number;
          char_idx_d = '0;
          cnt_d      = '0;
          bit_idx_d  = 3'd0;
          state_d    = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        shift_d = char_at(char_idx_q, snap_q);
        cnt_d   = '0;
        state_d = S_START;
      end

      S_START: begin
        tx_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        tx_d = shift_q[0];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (char_idx_q < CIDX_LAST) begin
            char_idx_d = char_idx_q + 1'b1;
            state_d    = S_LOAD;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_number_reporter.sv
// Randomised scoreboard bench: stimulus queues expected bytes, a line-level UART monitor
// decodes tx and compares every received frame against the queue.
module tb_uart_number_reporter;

  localparam int CPB       = 4;
  localparam int BYTE_CYC  = 10 * CPB + 1;
  localparam int BUSY_CYC  = 6 * BYTE_CYC + 1;

  logic        clk;
  logic        rst_n;
  logic        send;
  logic [15:0] number;
  logic        busy;
  logic        done;
  logic        tx;

  logic [7:0]  exp_q [$];
  int          n_cmp;
  int          n_err;

  uart_number_reporter #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(400),
    .BAUD_RATE                  (100),
    .NUMBER_OF_DIGITS           (4),
    .NUMBER_OF_BITS_PER_DIGIT   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .send  (send),
    .number(number),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: text of a report is the hex digits MSD first, then CR LF.
  function automatic logic [7:0] ref_char(input logic [15:0] num, input int i);
    int v;
    if (i < 4) begin
      v = (int'(num) >> (4 * (3 - i))) % 16;
      ref_char = (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    end else if (i == 4) begin
      ref_char = 8'h0D;
    end else begin
      ref_char = 8'h0A;
    end
  endfunction

  task automatic push_report(input logic [15:0] num);
    for (int i = 0; i < 6; i++) exp_q.push_back(ref_char(num, i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line monitor: 40 samples per frame, every bit must hold steady for exactly CPB samples.
  initial begin : monitor
    logic       prev;
    logic       in_frame;
    logic       samp [0:39];
    int         t;
    logic [7:0] got;
    logic [7:0] want;
    logic       frame_ok;
    prev     = 1'b1;
    in_frame = 1'b0;
    t        = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        in_frame = 1'b0;
        prev     = 1'b1;
      end else if (!in_frame) begin
        if (prev && !tx) begin
          in_frame = 1'b1;
          t        = 0;
          samp[0]  = tx;
        end
        prev = tx;
      end else begin
        t++;
        samp[t] = tx;
        if (t == 39) begin
          frame_ok = (samp[0] == 1'b0) && (samp[36] == 1'b1);
          for (int b = 0; b < 10; b++)
            for (int s = 1; s < CPB; s++)
              if (samp[b * CPB + s] !== samp[b * CPB]) frame_ok = 1'b0;
          for (int b = 0; b < 8; b++) got[b] = samp[(b + 1) * CPB + 2];
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'h0, got}, 32'hFFFF_FFFF);
          end else begin
            want = exp_q.pop_front();
            check("byte", {23'h0, frame_ok, got}, {23'h0, 1'b1, want});
          end
          in_frame = 1'b0;
          prev     = tx;
        end
      end
    end
  end

  // One report: optional extra send pulse at cycle mid_send_at, number change at change_at.
  task automatic run_report(input logic [15:0] num, input int mid_send_at,
                            input int change_at, input logic [15:0] late_num);
    int   busy_fall;
    int   done_cnt;
    int   done_at;
    logic tx1;
    logic tx2;
    busy_fall = -1;
    done_cnt  = 0;
    done_at   = -1;
    tx1       = 1'bx;
    tx2       = 1'bx;
    number    = num;
    send      = 1'b1;
    tick();
    send = 1'b0;
    push_report(num);
    for (int j = 0; j <= 300; j++) begin
      if (j == 1) tx1 = tx;
      if (j == 2) tx2 = tx;
      if (!busy && busy_fall < 0) busy_fall = j;
      if (done) begin
        done_cnt++;
        done_at = j;
      end
      send = (j == mid_send_at);
      if (j == change_at) number = late_num;
      tick();
    end
    send = 1'b0;
    check("start_edge", {30'h0, tx1, tx2}, 32'h2);
    check("busy_time", busy_fall, BUSY_CYC);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, BUSY_CYC);
    check("no_restart", {31'h0, busy}, 32'h0);
    check("bytes_drained", exp_q.size(), 0);
  endtask

  initial begin : stimulus
    int bad;
    int done_cnt;
    int done_at;
    int r_mid;
    int r_chg;
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    send   = 1'b0;
    number = 16'h0000;
    repeat (3) tick();
    check("reset_outputs", {29'h0, tx, busy, done}, 32'h4);
    rst_n = 1'b1;
    tick();

    run_report(16'h1234, -1, -1, 16'h0000);
    run_report(16'h0AF9, -1, -1, 16'h0000);
    run_report(16'h5678, 100, -1, 16'h0000);
    run_report(16'hC0DE, 246, -1, 16'h0000);
    run_report(16'h1234, -1, 1, 16'h9999);

    // Reset in the middle of the second byte's data bits.
    number = 16'hBEEF;
    send   = 1'b1;
    tick();
    send = 1'b0;
    push_report(16'hBEEF);
    repeat (BYTE_CYC + 15) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_midframe", {29'h0, tx, busy, done}, 32'h4);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    run_report(16'hBEEF, -1, -1, 16'h0000);

    // Idle line stays quiet.
    bad = 0;
    for (int j = 0; j < 1000; j++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      tick();
    end
    check("idle_quiet", bad, 0);

    // send held high: back-to-back reports, each restarting on return to IDLE.
    number   = 16'h0042;
    send     = 1'b1;
    done_cnt = 0;
    done_at  = -1;
    tick();
    push_report(16'h0042);
    push_report(16'h0042);
    for (int j = 0; j <= 560; j++) begin
      if (done) begin
        done_cnt++;
        done_at = j;
      end
      if (j == BUSY_CYC + 1) send = 1'b0;
      tick();
    end
    check("held_done_count", done_cnt, 2);
    check("held_second_done", done_at, 2 * BUSY_CYC + 1);
    check("held_drained", exp_q.size(), 0);

    for (int k = 0; k < 8; k++) begin
      r_mid = ($urandom_range(1, 0) == 1) ? int'($urandom_range(246, 3)) : -1;
      r_chg = int'($urandom_range(200, 1));
      run_report(16'($urandom), r_mid, r_chg, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
